// File: rtl/pwm_ramp_bank.sv
// pwm_ramp_bank: multi-channel PWM with a shared period counter and per-channel soft-start duty ramp.
// Define PWM_RAMP_BANK_STAGGER_EN to offset each channel's phase by i*(PERIOD/CHANNELS).
module pwm_ramp_bank #(
    parameter int CHANNELS  = 4,
    parameter int PERIOD    = 6000,
    parameter int W         = $clog2(PERIOD + 1),
    parameter int RAMP_STEP = 64,
    parameter int RAMP_DIV  = 1,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int RDW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic [W-1:0]        wr_duty,
    input  logic                wr_immediate,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] at_target,
    output logic                period_start
);

    logic [W-1:0]          cnt_r;
    logic [RDW-1:0]        rdiv_r;
    logic                  ready_en_r;
    logic [W-1:0]          tgt_r [CHANNELS];
    logic [W-1:0]          cur_r [CHANNELS];
    logic [CHANNELS-1:0]   pend_r;
    logic [CHANNELS-1:0]   out_r;
    logic [CHANNELS-1:0]   at_target_r;
    logic                  period_start_r;

    logic                  boundary_s;
    logic                  ramp_upd_s;
    logic                  wr_fire_s;
    logic [W-1:0]          wr_sat_s;
    logic [W-1:0]          phase_s [CHANNELS];
    logic [CHANNELS-1:0]   pwm_s;
    logic [CHANNELS-1:0]   at_s;

    // One bounded slew step of cur toward tgt; never overshoots.
    function automatic logic [W-1:0] ramp_next(input logic [W-1:0] cur_v, input logic [W-1:0] tgt_v);
        int unsigned diff_v;
        int unsigned step_v;
        logic [W-1:0] res_v;
        if (tgt_v >= cur_v) begin
            diff_v = 32'(tgt_v - cur_v);
        end else begin
            diff_v = 32'(cur_v - tgt_v);
        end
        step_v = (diff_v < 32'(RAMP_STEP)) ? diff_v : 32'(RAMP_STEP);
        if (tgt_v >= cur_v) begin
            res_v = cur_v + W'(step_v);
        end else begin
            res_v = cur_v - W'(step_v);
        end
        return res_v;
    endfunction

`ifdef PWM_RAMP_BANK_STAGGER_EN
    // Channel phase offset wrapped back into 0..PERIOD-1.
    function automatic logic [W-1:0] stagger_phase(input logic [W-1:0] cnt_v, input int unsigned idx_v);
        int unsigned sum_v;
        sum_v = 32'(cnt_v) + idx_v * 32'(PERIOD / CHANNELS);
        if (sum_v >= 32'(PERIOD)) begin
            sum_v = sum_v - 32'(PERIOD);
        end else begin
            sum_v = sum_v;
        end
        return W'(sum_v);
    endfunction
`endif

    assign boundary_s = ena && (cnt_r == W'(PERIOD - 1));
    assign ramp_upd_s = boundary_s && (rdiv_r == RDW'(RAMP_DIV - 1));
    // Writes are refused at the boundary so they never race the cur update.
    assign wr_ready   = ready_en_r && !boundary_s;
    assign wr_fire_s  = wr_valid && wr_ready && (32'(wr_chan) < 32'(CHANNELS));
    assign wr_sat_s   = (32'(wr_duty) > 32'(PERIOD)) ? W'(PERIOD) : wr_duty;

    // Per-channel phase and next-cycle PWM / at-target values.
    always_comb begin
        pwm_s = {CHANNELS{1'b0}};
        at_s  = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_RAMP_BANK_STAGGER_EN
            phase_s[i] = stagger_phase(cnt_r, 32'(i));
`else
            phase_s[i] = cnt_r;
`endif
            pwm_s[i] = (phase_s[i] < cur_r[i]);
            at_s[i]  = (cur_r[i] == tgt_r[i]);
        end
    end

    // Period counter, ramp divider and post-reset ready enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r      <= {W{1'b0}};
            rdiv_r     <= {RDW{1'b0}};
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (ena) begin
                cnt_r <= (cnt_r == W'(PERIOD - 1)) ? {W{1'b0}} : cnt_r + W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (boundary_s) begin
                rdiv_r <= (rdiv_r == RDW'(RAMP_DIV - 1)) ? {RDW{1'b0}} : rdiv_r + RDW'(1);
            end else begin
                rdiv_r <= rdiv_r;
            end
        end
    end

    // Target capture, immediate-jump flags and boundary-only duty updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                tgt_r[i] <= {W{1'b0}};
                cur_r[i] <= {W{1'b0}};
            end
            pend_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_fire_s && (32'(wr_chan) == 32'(i))) begin
                    tgt_r[i] <= wr_sat_s;
                    if (wr_immediate) begin
                        pend_r[i] <= 1'b1;
                    end else begin
                        pend_r[i] <= pend_r[i];
                    end
                end else if (boundary_s && pend_r[i]) begin
                    cur_r[i]  <= tgt_r[i];
                    pend_r[i] <= 1'b0;
                end else if (ramp_upd_s) begin
                    cur_r[i] <= ramp_next(cur_r[i], tgt_r[i]);
                end else begin
                    cur_r[i] <= cur_r[i];
                end
            end
        end
    end

    // Registered outputs; PWM pins freeze while ena is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_r          <= {CHANNELS{1'b0}};
            at_target_r    <= {CHANNELS{1'b1}};
            period_start_r <= 1'b0;
        end else begin
            period_start_r <= boundary_s;
            at_target_r    <= at_s;
            if (ena) begin
                out_r <= pwm_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign out          = out_r;
    assign at_target    = at_target_r;
    assign period_start = period_start_r;

endmodule
